// File: rtl/hs_send_arb_if.sv
// Channel-side bundle of hs_send_arb: per-channel payload/request/grant plus the
// toggle request/acknowledge pair towards the receive domain.
interface hs_send_arb_if #(
  parameter int WIDTH_D = 8,
  parameter int NCH     = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH_D-1:0] adata;
  logic [NCH-1:0]         asend;
  logic [NCH-1:0]         aready;
  logic [WIDTH_D-1:0]     dout;
  logic [CHW-1:0]         dch;
  logic                   a_req;
  logic                   b_ack;

  modport master (
    output adata, asend, b_ack,
    input  aready, dout, dch, a_req
  );

  modport slave (
    input  adata, asend, b_ack,
    output aready, dout, dch, a_req
  );
endinterface

// File: rtl/hs_send_arb.sv
// Round-robin arbiter over NCH senders feeding one toggle-handshake link into an
// asynchronous receive domain, with an optional acknowledge timeout.
module hs_send_arb #(
  parameter int WIDTH_D     = 8,
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic          aclk,
  input  logic          arst_n,
  hs_send_arb_if.slave  bus,
  input  logic          err_clr,
  output logic          busy,
  output logic          timeout_err,
  output logic [1:0]    dbg_state
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [WIDTH_D-1:0]     dout_q, dout_d;
  logic [CHW-1:0]         dch_q, dch_d;
  logic [CHW-1:0]         rr_q, rr_d;
  logic                   a_req_q, a_req_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   terr_q, terr_d;

  logic                   ack_s;
  logic                   done;
  logic                   accept;
  logic [NCH-1:0]         gnt;
  logic                   gnt_any;
  logic [CHW-1:0]         gnt_idx;
  logic [CHW-1:0]         gnt_nxt;
  logic [WIDTH_D-1:0]     gnt_data;

  // b_ack is only ever sampled by the first synchroniser flop.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.b_ack};
  assign ack_s  = sync_q[SYNC_STAGES-1];
  assign done   = (ack_s == a_req_q);

  always_comb begin
    int c;
    c        = 0;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_nxt  = '0;
    gnt_data = '0;
    for (int k = 0; k < NCH; k++) begin
      c = (int'(rr_q) + k) % NCH;
      if (!gnt_any && bus.asend[c]) begin
        gnt_any  = 1'b1;
        gnt[c]   = 1'b1;
        gnt_idx  = CHW'(c);
        gnt_nxt  = CHW'((c + 1) % NCH);
        gnt_data = bus.adata[c*WIDTH_D +: WIDTH_D];
      end
    end
  end

  // Handshake: channel i transfers on a rising edge where asend[i] & aready[i];
  // asend is a level held by the sender until then, aready is only offered in IDLE.
  assign bus.aready = (state_q == S_IDLE) ? gnt : '0;
  assign accept     = (state_q == S_IDLE) && gnt_any;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    dch_d   = dch_q;
    rr_d    = rr_q;
    a_req_d = a_req_q;
    timer_d = timer_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          dout_d  = gnt_data;
          dch_d   = gnt_idx;
          a_req_d = ~a_req_q;
          rr_d    = gnt_nxt;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (done) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (TIMEOUT > 0) begin
          if (timer_q == T_LAST) begin
            state_d = S_ERR;
            terr_d  = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_ERR: begin
        if (err_clr) begin
          terr_d  = 1'b0;
          timer_d = '0;
          state_d = done ? S_IDLE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      dout_q  <= '0;
      dch_q   <= '0;
      rr_q    <= '0;
      a_req_q <= 1'b0;
      timer_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      dout_q  <= dout_d;
      dch_q   <= dch_d;
      rr_q    <= rr_d;
      a_req_q <= a_req_d;
      timer_q <= timer_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dch     = dch_q;
  assign bus.a_req   = a_req_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_hs_send_arb.sv
// Bench for hs_send_arb: directed send/fairness/timeout/race/reset cases plus a
// randomized run scored against a round-robin transfer model.
module tb_hs_send_arb;
  logic aclk   = 1'b0;
  logic arst_n = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;
  int sel   = 0;

  logic [3:0]  r_asend = '0;
  logic [31:0] r_adata [4];
  logic        r_back0 = 1'b0;
  logic        r_back2 = 1'b0;
  logic        err_clr0 = 1'b0, err_clr1 = 1'b0, err_clr2 = 1'b0;
  logic        busy0, busy1, busy2, terr0, terr1, terr2;
  logic [1:0]  st0, st1, st2;

  hs_send_arb_if #(.WIDTH_D(8),  .NCH(4)) b0();
  hs_send_arb_if #(.WIDTH_D(8),  .NCH(4)) b1();
  hs_send_arb_if #(.WIDTH_D(32), .NCH(1)) b2();

  assign b0.asend = (sel != 0) ? 4'b0 : r_asend;
  assign b0.adata = {r_adata[3][7:0], r_adata[2][7:0], r_adata[1][7:0], r_adata[0][7:0]};
  assign b0.b_ack = r_back0;
  assign b2.asend = (sel != 0) ? r_asend[0] : 1'b0;
  assign b2.adata = r_adata[0];
  assign b2.b_ack = r_back2;

  logic [31:0] r_dout;
  logic [3:0]  r_dch, r_aready;
  logic        r_areq, r_busy;
  assign r_dout   = (sel != 0) ? b2.dout : {24'b0, b0.dout};
  assign r_dch    = (sel != 0) ? {3'b0, b2.dch} : {2'b0, b0.dch};
  assign r_aready = (sel != 0) ? {3'b0, b2.aready} : b0.aready;
  assign r_areq   = (sel != 0) ? b2.a_req : b0.a_req;
  assign r_busy   = (sel != 0) ? busy2 : busy0;

  hs_send_arb #(.WIDTH_D(8), .NCH(4), .SYNC_STAGES(2), .TIMEOUT(0)) u0 (
    .aclk(aclk), .arst_n(arst_n), .bus(b0), .err_clr(err_clr0),
    .busy(busy0), .timeout_err(terr0), .dbg_state(st0));
  hs_send_arb #(.WIDTH_D(8), .NCH(4), .SYNC_STAGES(2), .TIMEOUT(16)) u1 (
    .aclk(aclk), .arst_n(arst_n), .bus(b1), .err_clr(err_clr1),
    .busy(busy1), .timeout_err(terr1), .dbg_state(st1));
  hs_send_arb #(.WIDTH_D(32), .NCH(1), .SYNC_STAGES(3), .TIMEOUT(0)) u2 (
    .aclk(aclk), .arst_n(arst_n), .bus(b2), .err_clr(err_clr2),
    .busy(busy2), .timeout_err(terr2), .dbg_state(st2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    r_asend  = '0;
    r_back0  = 1'b0;
    r_back2  = 1'b0;
    b1.asend = '0;
    b1.b_ack = 1'b0;
    err_clr1 = 1'b0;
    arst_n   = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
    tick();
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Model: a transfer is granted to the first pending channel at or after the
  // pointer (one past the last winner); it stays busy until SYNC+1 edges after
  // the receiver's toggle. Delivered payloads are scored through exp_q.
  task automatic run_random(input int nch, input logic [31:0] mask, input int sync,
                            input int ntx, input int budget, input string nm);
    logic [3:0]  held = '0;
    logic [3:0]  exp_rdy;
    logic [31:0] exp_q[$];
    int          ch_q[$];
    logic [31:0] last_data = '0;
    int          last_ch = 0;
    int          ptr = 0;
    int          cnt = 0;
    int          wdly = 0;
    int          pick;
    int          done_n = 0;
    int          cyc = 0;
    bit          mbusy = 1'b0;
    bit          mareq = 1'b0;
    bit          wait_on = 1'b0;
    bit          acc = 1'b0;
    while (done_n < ntx && cyc < budget) begin
      tick();
      cyc++;
      if (acc) begin
        mbusy     = 1'b1;
        mareq     = ~mareq;
        last_data = exp_q.pop_front();
        last_ch   = ch_q.pop_front();
        ptr       = (last_ch + 1) % nch;
        held[last_ch] = 1'b0;
        wait_on   = 1'b1;
        wdly      = $urandom_range(0, 4);
        done_n++;
      end
      check({nm, " dout"}, r_dout, last_data);
      check({nm, " dch"}, r_dch, last_ch);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) mbusy = 1'b0;
      end
      check({nm, " busy"}, r_busy, mbusy);
      check({nm, " a_req"}, r_areq, mareq);
      if (wait_on) begin
        if (wdly == 0) begin
          if (sel != 0) r_back2 = ~r_back2;
          else          r_back0 = ~r_back0;
          wait_on = 1'b0;
          cnt     = sync + 1;
        end else begin
          wdly--;
        end
      end
      for (int c = 0; c < nch; c++) begin
        if (!held[c] && $urandom_range(0, 2) == 0) held[c] = 1'b1;
        r_adata[c] = $urandom;
      end
      r_asend = held;
      #1;
      exp_rdy = '0;
      pick    = -1;
      if (!mbusy) begin
        for (int k = 0; k < nch; k++)
          if (pick < 0 && held[(ptr + k) % nch]) pick = (ptr + k) % nch;
      end
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      check({nm, " aready"}, r_aready, exp_rdy);
      acc = (pick >= 0);
      if (acc) begin
        exp_q.push_back(r_adata[pick] & mask);
        ch_q.push_back(pick);
      end
    end
    check({nm, " transfer count"}, done_n, ntx);
    r_asend = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          got;
    int          acc_c;
    bit          acc;
    logic [7:0]  acc_d, held_d;
    int          exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 4; c++) r_adata[c] = '0;
    b1.asend = '0;
    b1.adata = '0;
    b1.b_ack = 1'b0;

    // Reset state of all three instances
    tick();
    tick();
    check("rst dout0", b0.dout, 0);
    check("rst dch0", b0.dch, 0);
    check("rst a_req0", b0.a_req, 0);
    check("rst busy0", busy0, 0);
    check("rst terr1", terr1, 0);
    check("rst a_req1", b1.a_req, 0);
    check("rst dout2", b2.dout, 0);
    check("rst busy2", busy2, 0);
    arst_n = 1'b1;
    tick();

    // Single send on channel 2, long stale acknowledge with timeout disabled
    sel = 0;
    for (int c = 0; c < 4; c++) r_adata[c] = $urandom;
    r_adata[2] = 32'hA5;
    r_asend    = 4'b0100;
    #1;
    check("send aready", b0.aready, 4'b0100);
    tick();
    r_asend = '0;
    check("send dout", b0.dout, 8'hA5);
    check("send dch", b0.dch, 2);
    check("send a_req", b0.a_req, 1);
    check("send busy", busy0, 1);
    #1;
    check("send aready off", b0.aready, 0);
    for (int i = 0; i < 20; i++) tick();
    check("no-timeout busy", busy0, 1);
    check("no-timeout terr", terr0, 0);
    r_back0 = 1'b1;
    tick();
    tick();
    check("ack latency busy", busy0, 1);
    tick();
    check("ack done busy", busy0, 0);

    // Reset mid-transfer, then fairness from a cleared pointer
    r_asend = 4'b0100;
    #1;
    check("rst2 aready", b0.aready, 4'b0100);
    tick();
    r_asend = '0;
    check("rst2 busy before", busy0, 1);
    #2;
    arst_n  = 1'b0;
    r_back0 = 1'b0;
    #1;
    check("rst2 dout", b0.dout, 0);
    check("rst2 dch", b0.dch, 0);
    check("rst2 a_req", b0.a_req, 0);
    check("rst2 busy", busy0, 0);
    @(posedge aclk);
    #1;
    arst_n = 1'b1;
    r_asend = 4'b1111;
    got = 0;
    held_d = '0;
    for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
      for (int c = 0; c < 4; c++) r_adata[c] = $urandom;
      #1;
      acc = 1'b0;
      if (b0.aready != 0) begin
        acc   = 1'b1;
        acc_c = oh_idx(b0.aready);
        acc_d = r_adata[acc_c][7:0];
        check("fair onehot", $countones(b0.aready), 1);
      end
      tick();
      r_back0 = b0.a_req;
      if (acc) begin
        check("fair grant", acc_c, exp_order[got]);
        check("fair dout", b0.dout, acc_d);
        held_d = acc_d;
        got++;
      end else if (busy0) begin
        check("fair hold", b0.dout, held_d);
      end
    end
    check("fair count", got, 5);
    r_asend = '0;

    // Randomized four-channel traffic
    do_reset();
    sel = 0;
    run_random(4, 32'h0000_00FF, 2, 40, 2000, "rnd4");

    // Timeout, error clear with stale ack, then completion
    do_reset();
    b1.adata = $urandom;
    b1.asend = 4'b0001;
    #1;
    check("to aready", b1.aready, 4'b0001);
    tick();
    b1.asend = '0;
    for (int i = 1; i <= 15; i++) tick();
    check("to pre terr", terr1, 0);
    check("to pre busy", busy1, 1);
    tick();
    check("to terr", terr1, 1);
    check("to err busy", busy1, 1);
    check("to err a_req", b1.a_req, 1);
    b1.asend = 4'b1111;
    #1;
    check("to err no grant", b1.aready, 0);
    b1.asend = '0;
    err_clr1 = 1'b1;
    tick();
    err_clr1 = 1'b0;
    check("to clr terr", terr1, 0);
    check("to clr busy", busy1, 1);
    check("to clr a_req", b1.a_req, 1);
    b1.b_ack = 1'b1;
    tick();
    tick();
    check("to ack busy", busy1, 1);
    tick();
    check("to idle busy", busy1, 0);
    check("to idle terr", terr1, 0);

    // Race: ack_s matches exactly when the timer reaches its last value
    b1.asend = 4'b0010;
    #1;
    check("race aready", b1.aready, 4'b0010);
    tick();
    b1.asend = '0;
    check("race a_req", b1.a_req, 0);
    for (int i = 1; i <= 13; i++) tick();
    b1.b_ack = 1'b0;
    tick();
    tick();
    check("race busy", busy1, 1);
    tick();
    check("race idle", busy1, 0);
    check("race terr", terr1, 0);

    // Single-channel wide sweep with deeper synchroniser
    do_reset();
    sel = 1;
    run_random(1, 32'hFFFF_FFFF, 3, 100, 5000, "sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hs_send_arb.md
HS_SEND_ARB -- requirements
Module: hs_send_arb

Interface
REQ-001 Parameter WIDTH_D, default 8, payload width in bits per channel.
REQ-002 Parameter NCH, default 4, number of sending channels (legal range 1..16).
REQ-003 Parameter SYNC_STAGES, default 2, flip-flop depth of the b_ack synchroniser (legal range 2..4).
REQ-004 Parameter TIMEOUT, default 0, maximum acknowledge wait in aclk cycles; 0 disables the timeout.
REQ-005 Derived constant CHW = max(1, clog2(NCH)).
REQ-006 aclk  in  1  single clock; all logic is rising-edge.
REQ-007 arst_n  in  1  asynchronous active-low reset.
REQ-008 adata  in  NCH*WIDTH_D  channel i payload is bits [i*WIDTH_D +: WIDTH_D].
REQ-009 asend  in  NCH  per-channel send request, level, held until accepted.
REQ-010 b_ack  in  1  toggle acknowledge from the receive domain, asynchronous to aclk.
REQ-011 err_clr  in  1  one-cycle clear of the timeout error.
REQ-012 dout  out  WIDTH_D  registered payload, stable while a transfer is outstanding.
REQ-013 dch  out  CHW  registered channel index of dout.
REQ-014 a_req  out  1  toggle request to the receive domain.
REQ-015 aready  out  NCH  per-channel grant/ready indication.
REQ-016 busy  out  1  transfer outstanding (state is WAIT_ACK or ERR).
REQ-017 timeout_err  out  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, WAIT_ACK and ERR.
REQ-019 b_ack SHALL pass through SYNC_STAGES flops to produce ack_s; no other logic SHALL sample b_ack.
REQ-020 The arbiter SHALL compute a combinational one-hot gnt over asend, using round-robin priority that starts at rr_ptr and wraps from NCH-1 to 0.
REQ-021 aready[i] SHALL equal (state==IDLE) & gnt[i]; at most one aready bit SHALL be high; aready may depend combinationally on asend.
REQ-022 A transfer SHALL be accepted on an edge where asend[i] & aready[i]; at that edge dout<=adata slice i, dch<=i, a_req<=~a_req, rr_ptr<=(i+1) mod NCH, state<=WAIT_ACK, and the timer clears.
REQ-023 With no accepted transfer, dout, dch, a_req and rr_ptr SHALL hold their values.
REQ-024 Completion condition: ack_s==a_req; in WAIT_ACK this condition SHALL move the FSM to IDLE on the next edge.
REQ-025 Latency: a b_ack toggle SHALL be reflected in ack_s after SYNC_STAGES edges, and state SHALL reach IDLE one edge later.
REQ-026 A new acceptance SHALL be possible in the first IDLE cycle, giving back-to-back transfers with no extra bubble.
REQ-027 If TIMEOUT>0, the timer SHALL increment each WAIT_ACK cycle; when it reaches TIMEOUT-1 without completion, state<=ERR and timeout_err<=1.
REQ-028 Completion and timeout in the same cycle: completion SHALL win (IDLE, no error).
REQ-029 TIMEOUT==0: the timer SHALL stay at 0 and ERR SHALL be unreachable.
REQ-030 In ERR no channel SHALL be granted and a_req SHALL hold; err_clr SHALL clear timeout_err and go to IDLE if ack_s==a_req, else to WAIT_ACK with the timer cleared.
REQ-031 busy SHALL equal (state != IDLE).
REQ-032 Timer width SHALL be clog2(TIMEOUT+1) bits, minimum 1; the timer SHALL never wrap.

Reset
REQ-033 On arst_n low the block SHALL asynchronously set: state=IDLE, dout=0, dch=0, a_req=0, all synchroniser flops=0, rr_ptr=0, timer=0, timeout_err=0.
REQ-034 Reset mid-transfer SHALL abandon the transfer; on release the block SHALL be in IDLE with aready governed by asend.
REQ-035 Reset release SHALL be synchronised externally to aclk; no internal release synchroniser.

Verification
REQ-036 Single send: NCH=4, asend=4'b0100, adata ch2=8'hA5 -> aready[2]=1 for one cycle, dout=A5, dch=2, a_req 0->1, busy=1; b_ack 0->1 -> busy=0 exactly SYNC_STAGES+1 edges later.
REQ-037 Fairness: asend=4'b1111 held, receiver echoes each a_req immediately -> grant order 0,1,2,3,0, and dout never changes while busy.
REQ-038 Timeout: TIMEOUT=16, b_ack held constant -> ERR and timeout_err=1 16 cycles after acceptance; err_clr with b_ack still stale -> WAIT_ACK, timeout_err=0; b_ack toggles -> IDLE.
REQ-039 Race: b_ack toggled so that ack_s matches in the same cycle the timer hits TIMEOUT-1 -> IDLE, timeout_err stays 0.
REQ-040 Reset mid-transfer: arst_n pulsed low while in WAIT_ACK -> all outputs zero immediately; after release asend=4'b0001 -> channel 0 is granted first.
REQ-041 Sweep: NCH=1, SYNC_STAGES=3, WIDTH_D=32, 100 random transfers with random ack delay -> every payload is delivered once, in order, with correct dch=0.
